// File: rtl/serial_fsub.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop,
// iterated LSB first behind val/rdy request and response handshakes.
module serial_fsub #(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_a,
  input  logic [nbits-1:0] in_b,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_diff,
  output logic             out_bout
);

  localparam int CW = $clog2(nbits) + 1;
  localparam logic [CW-1:0] LAST = CW'(nbits - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic             rdy_r;
  logic             val_r;
  logic [nbits-1:0] a_r;
  logic [nbits-1:0] b_r;
  logic [nbits-1:0] diff_r;
  logic             bor_r;
  logic [CW-1:0]    cnt_r;

  logic             x;
  logic             y;
  logic             z;
  logic             d;
  logic             bnext;
  logic [nbits:0]   diff_cat;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  always_comb begin
    x        = a_r[0];
    y        = b_r[0];
    z        = bor_r;
    d        = x ^ y ^ z;
    bnext    = (~x & y) | (~x & z) | (y & z);
    diff_cat = {d, diff_r};
  end

  // Handshake flags are state decodes, masked while reset is held.
  assign in_rdy   = rdy_r & ~reset;
  assign out_val  = val_r & ~reset;
  assign out_diff = diff_r;
  assign out_bout = bor_r;

  // Control FSM and serial datapath, advanced once per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rdy_r  <= 1'b1;
      val_r  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      diff_r <= '0;
      bor_r  <= 1'b0;
      cnt_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_val) begin
            a_r   <= in_a;
            b_r   <= in_b;
            bor_r <= 1'b0;
            cnt_r <= '0;
            rdy_r <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          a_r    <= a_r >> 1;
          b_r    <= b_r >> 1;
          diff_r <= diff_cat[nbits:1];
          bor_r  <= bnext;
          cnt_r  <= cnt_r + 1'b1;
          if (cnt_r == LAST) begin
            val_r <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            val_r <= 1'b0;
            rdy_r <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          val_r <= 1'b0;
          rdy_r <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
